// File: rtl/cpu_err_pkg.sv
// Shared CPU error definitions: error codes, error-collector FSM encoding, and
// a helper for index widths.
package cpu_err_pkg;

    localparam int NO_ERROR             = 0;
    localparam int ERROR_DIV_BY_ZERO    = 1;
    localparam int ERROR_MEM_ACCESS_ERR = 2;
    localparam int ERROR_IS_OPCODE_ERR  = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        REPORT = 1'b1
    } err_state_t;

    // A single source still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/error_collect_if.sv
// Error-collector bus: source pulses, masking and faulting PC in; the report
// and PCU handshake plus status out.
interface error_collect_if #(
    parameter int N_SRC = 3,
    parameter int ERR_W = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = 8
);
    logic [N_SRC-1:0] src_err;
    logic [N_SRC-1:0] src_mask;
    logic [PC_W-1:0]  cur_pc;
    logic             pcu_ack;
    logic             err_valid;
    logic [ERR_W-1:0] cpu_error;
    logic [PC_W-1:0]  err_pc;
    logic [N_SRC-1:0] err_pending;
    logic [CNT_W-1:0] drop_cnt;
    logic             halt_req;

    modport master (
        output src_err, src_mask, cur_pc, pcu_ack,
        input  err_valid, cpu_error, err_pc, err_pending, drop_cnt, halt_req
    );

    modport slave (
        input  src_err, src_mask, cur_pc, pcu_ack,
        output err_valid, cpu_error, err_pc, err_pending, drop_cnt, halt_req
    );
endinterface

// File: rtl/prio_enc.sv
// Lowest-set-index priority encoder with an any-request flag.
module prio_enc
    import cpu_err_pkg::*;
#(
    parameter int N_SRC = 3,
    parameter int IDX_W = idx_w(N_SRC)
) (
    input  logic [N_SRC-1:0] i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);
    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        o_idx   = '0;
        o_valid = |i_req;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = IDX_W'(i);
        end
    end
endmodule

// File: rtl/error_collect.sv
// Captures error pulses into sticky pending bits and reports them one at a time
// to the PCU, lowest index first, holding each report until acknowledged.
module error_collect
    import cpu_err_pkg::*;
#(
    parameter int               N_SRC     = 3,
    parameter int               ERR_W     = 4,
    parameter int               PC_W      = 32,
    parameter int               CNT_W     = 8,
    parameter logic [N_SRC-1:0] HALT_MASK = {N_SRC{1'b1}}
) (
    input  logic           clk,
    input  logic           rst,
    error_collect_if.slave bus
);
    localparam int IDX_W = idx_w(N_SRC);
    localparam int POP_W = $clog2(N_SRC + 1);
    localparam int SUM_W = CNT_W + POP_W + 1;

    generate
        if ((2 ** ERR_W) <= N_SRC) begin : g_bad_err_w
            $error("error_collect: ERR_W too narrow to encode N_SRC error codes");
        end
    endgenerate

    err_state_t       r_state;
    logic [N_SRC-1:0] r_pending;
    logic [IDX_W-1:0] r_sel;
    logic [ERR_W-1:0] r_code;
    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_drop;
    logic             r_halt;

    logic [N_SRC-1:0] w_new;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_coal;
    logic [N_SRC-1:0] w_cand;
    logic [IDX_W-1:0] w_sel;
    logic             w_any;
    logic [POP_W-1:0] w_pop;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [POP_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > {{(POP_W + 1){1'b0}}, {CNT_W{1'b1}}}) return '1;
        return s[CNT_W-1:0];
    endfunction

    assign w_new  = bus.src_err & ~bus.src_mask;
    assign w_clr  = ((r_state == REPORT) && bus.pcu_ack) ? (N_SRC'(1) << r_sel) : '0;
    // A pulse landing on an already-pending bit that is not being cleared is lost.
    assign w_coal = w_new & r_pending & ~w_clr;
    assign w_cand = r_pending | w_new;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_SRC; i++) w_pop = w_pop + POP_W'(w_coal[i]);
    end

    prio_enc #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_prio (
        .i_req   (w_cand),
        .o_idx   (w_sel),
        .o_valid (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_sel     <= '0;
            r_code    <= ERR_W'(NO_ERROR);
            r_pc      <= '0;
            r_drop    <= '0;
            r_halt    <= 1'b0;
        end else begin
            // Set wins over clear, so a fresh pulse on the acked source re-arms it.
            r_pending <= (r_pending & ~w_clr) | w_new;
            r_drop    <= sat_add(r_drop, w_pop);
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= REPORT;
                        r_sel   <= w_sel;
                        r_code  <= ERR_W'(w_sel) + ERR_W'(ERROR_DIV_BY_ZERO);
                        r_pc    <= bus.cur_pc;
                        r_halt  <= HALT_MASK[w_sel];
                    end
                end
                REPORT: begin
                    if (bus.pcu_ack) begin
                        r_state <= IDLE;
                        r_code  <= ERR_W'(NO_ERROR);
                        r_halt  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.err_valid   = (r_state == REPORT);
    assign bus.cpu_error   = r_code;
    assign bus.err_pc      = r_pc;
    assign bus.err_pending = r_pending;
    assign bus.drop_cnt    = r_drop;
    assign bus.halt_req    = r_halt;
endmodule

// File: tb/tb_error_collect.sv
// Directed bench for error_collect (N_SRC=3, CNT_W=2, HALT_MASK=3'b011); the
// expected outputs of every cycle are queued when the stimulus is driven.
module tb_error_collect;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    error_collect_if #(.N_SRC(3), .ERR_W(4), .PC_W(32), .CNT_W(2)) bus ();

    error_collect #(
        .N_SRC(3), .ERR_W(4), .PC_W(32), .CNT_W(2), .HALT_MASK(3'b011)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       tag;
        logic        valid;
        logic [3:0]  code;
        logic [31:0] pc;
        logic        pc_chk;
        logic [2:0]  pend;
        logic [1:0]  drop;
        logic        halt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_front();
        exp_t e;
        e = sb.pop_front();
        n_vec++;
        assert (bus.err_valid === e.valid) else begin
            n_err++;
            $error("FAIL %s.err_valid observed %0h expected %0h", e.tag, bus.err_valid, e.valid);
        end
        n_vec++;
        assert (bus.cpu_error === e.code) else begin
            n_err++;
            $error("FAIL %s.cpu_error observed %0h expected %0h", e.tag, bus.cpu_error, e.code);
        end
        n_vec++;
        assert (bus.err_pending === e.pend) else begin
            n_err++;
            $error("FAIL %s.err_pending observed %b expected %b", e.tag, bus.err_pending, e.pend);
        end
        n_vec++;
        assert (bus.drop_cnt === e.drop) else begin
            n_err++;
            $error("FAIL %s.drop_cnt observed %0d expected %0d", e.tag, bus.drop_cnt, e.drop);
        end
        n_vec++;
        assert (bus.halt_req === e.halt) else begin
            n_err++;
            $error("FAIL %s.halt_req observed %0h expected %0h", e.tag, bus.halt_req, e.halt);
        end
        if (e.pc_chk) begin
            n_vec++;
            assert (bus.err_pc === e.pc) else begin
                n_err++;
                $error("FAIL %s.err_pc observed %0h expected %0h", e.tag, bus.err_pc, e.pc);
            end
        end
    endtask

    // Queue what the outputs must be after the next rising edge, then compare.
    task automatic step(input string tag, input logic v, input logic [3:0] code,
                        input logic [31:0] pc, input logic pc_chk,
                        input logic [2:0] pend, input logic [1:0] drop, input logic halt);
        exp_t e;
        e.tag = tag; e.valid = v; e.code = code; e.pc = pc; e.pc_chk = pc_chk;
        e.pend = pend; e.drop = drop; e.halt = halt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_front();
    endtask

    initial begin
        rst          = 1'b1;
        bus.src_err  = '0;
        bus.src_mask = '0;
        bus.cur_pc   = '0;
        bus.pcu_ack  = 1'b0;

        step("rst0", 0, 0, 0, 1, 3'b000, 0, 0);
        step("rst1", 0, 0, 0, 1, 3'b000, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step("idle", 0, 0, 0, 1, 3'b000, 0, 0);

        // Single error from source 1
        bus.src_err = 3'b010; bus.cur_pc = 32'h100;
        step("single", 1, 2, 32'h100, 1, 3'b010, 0, 1);
        bus.src_err = '0;
        for (int i = 0; i < 5; i++) begin
            bus.cur_pc = 32'h104 + 32'(4 * i);
            step("hold", 1, 2, 32'h100, 1, 3'b010, 0, 1);
        end
        bus.pcu_ack = 1'b1;
        step("ack", 0, 0, 0, 0, 3'b000, 0, 0);
        step("ack_in_idle", 0, 0, 0, 0, 3'b000, 0, 0);
        bus.pcu_ack = 1'b0;

        // Simultaneous pulses: lower index first, deferred one takes the IDLE-cycle PC
        bus.src_err = 3'b110; bus.cur_pc = 32'h200;
        step("prio_a", 1, 2, 32'h200, 1, 3'b110, 0, 1);
        bus.src_err = '0; bus.pcu_ack = 1'b1; bus.cur_pc = 32'h250;
        step("prio_ack", 0, 0, 0, 0, 3'b100, 0, 0);
        bus.pcu_ack = 1'b0; bus.cur_pc = 32'h300;
        step("prio_b", 1, 3, 32'h300, 1, 3'b100, 0, 0);
        bus.pcu_ack = 1'b1;
        step("prio_done", 0, 0, 0, 0, 3'b000, 0, 0);
        bus.pcu_ack = 1'b0;

        // Coalescing, ack coinciding with a pulse, saturation at 3
        bus.src_err = 3'b001; bus.cur_pc = 32'h400;
        step("co_rep", 1, 1, 32'h400, 1, 3'b001, 0, 1);
        step("co_1", 1, 1, 32'h400, 1, 3'b001, 1, 1);
        bus.pcu_ack = 1'b1;
        step("co_ack_pulse", 0, 0, 0, 0, 3'b001, 1, 0);
        bus.src_err = '0; bus.pcu_ack = 1'b0; bus.cur_pc = 32'h500;
        step("co_rearm", 1, 1, 32'h500, 1, 3'b001, 1, 1);
        bus.src_err = 3'b001;
        step("co_2", 1, 1, 32'h500, 1, 3'b001, 2, 1);
        step("co_3", 1, 1, 32'h500, 1, 3'b001, 3, 1);
        step("co_sat1", 1, 1, 32'h500, 1, 3'b001, 3, 1);
        step("co_sat2", 1, 1, 32'h500, 1, 3'b001, 3, 1);
        bus.src_err = '0; bus.pcu_ack = 1'b1;
        step("co_done", 0, 0, 0, 0, 3'b000, 3, 0);
        bus.pcu_ack = 1'b0;
        step("co_idle", 0, 0, 0, 0, 3'b000, 3, 0);

        // Higher-priority pulse during a report waits its turn
        bus.src_err = 3'b100; bus.cur_pc = 32'h600;
        step("pre_a", 1, 3, 32'h600, 1, 3'b100, 3, 0);
        bus.src_err = 3'b001; bus.cur_pc = 32'h610;
        step("pre_hold", 1, 3, 32'h600, 1, 3'b101, 3, 0);
        bus.src_err = '0; bus.pcu_ack = 1'b1;
        step("pre_ack", 0, 0, 0, 0, 3'b001, 3, 0);
        bus.pcu_ack = 1'b0; bus.cur_pc = 32'h700;
        step("pre_b", 1, 1, 32'h700, 1, 3'b001, 3, 1);
        bus.pcu_ack = 1'b1;
        step("pre_done", 0, 0, 0, 0, 3'b000, 3, 0);
        bus.pcu_ack = 1'b0;

        // Masking blocks capture but not already-pending bits
        bus.src_mask = 3'b001; bus.src_err = 3'b001;
        step("mask_blk", 0, 0, 0, 0, 3'b000, 3, 0);
        bus.src_err = '0;
        step("mask_none", 0, 0, 0, 0, 3'b000, 3, 0);
        bus.src_mask = '0; bus.src_err = 3'b001; bus.cur_pc = 32'h800;
        step("mask_rep", 1, 1, 32'h800, 1, 3'b001, 3, 1);
        bus.src_err = 3'b010;
        step("mask_set", 1, 1, 32'h800, 1, 3'b011, 3, 1);
        bus.src_err = '0; bus.src_mask = 3'b011; bus.pcu_ack = 1'b1;
        step("mask_ack", 0, 0, 0, 0, 3'b010, 3, 0);
        bus.pcu_ack = 1'b0; bus.cur_pc = 32'h900; bus.src_err = 3'b010;
        step("mask_pend", 1, 2, 32'h900, 1, 3'b010, 3, 1);
        bus.src_err = '0; bus.pcu_ack = 1'b1;
        step("mask_done", 0, 0, 0, 0, 3'b000, 3, 0);
        bus.pcu_ack = 1'b0; bus.src_mask = '0;

        // Reset in the middle of a report
        bus.src_err = 3'b111; bus.cur_pc = 32'hA00;
        step("mr_rep", 1, 1, 32'hA00, 1, 3'b111, 3, 1);
        bus.src_err = '0; rst = 1'b1;
        step("mr_rst", 0, 0, 0, 1, 3'b000, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("mr_after", 0, 0, 0, 1, 3'b000, 0, 0);

        // Two coalesced bits in one cycle add two
        bus.src_err = 3'b011; bus.cur_pc = 32'hB00;
        step("pop_rep", 1, 1, 32'hB00, 1, 3'b011, 0, 1);
        step("pop_two", 1, 1, 32'hB00, 1, 3'b011, 2, 1);
        bus.src_err = '0; bus.pcu_ack = 1'b1;
        step("pop_ack", 0, 0, 0, 0, 3'b010, 2, 0);
        bus.pcu_ack = 1'b0; bus.cur_pc = 32'hC00;
        step("pop_next", 1, 2, 32'hC00, 1, 3'b010, 2, 1);
        bus.pcu_ack = 1'b1;
        step("pop_done", 0, 0, 0, 0, 3'b000, 2, 0);
        bus.pcu_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
